seq_detector_param: RTL and testbench

- Parametrised successor to the fixed four-ones edge detector. Detects a programmable PAT_LEN-bit serial pattern on input w.
- Adds an overlap/non-overlap mode, an input-valid qualifier, a synchronous clear, and a saturating match counter.
- Sits on a serial data path. Z is a single-cycle registered pulse used as an event strobe; cnt is status readback.

---
 rtl/seq_detector_param.sv | 49 ++++
 tb/tb_seq_detector_param.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable serial pattern detector with overlap mode,
// valid qualifier, synchronous clear and saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1111,
  parameter int                 CNT_W   = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             overlap,
  input  logic             w,
  output logic             Z,
  output logic [CNT_W-1:0] cnt
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  logic [PAT_LEN-1:0] hist_q, hist_d, nh;
  logic [FW-1:0]      fill_q, fill_d, nf;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_q, z_d, match, flush;
  always_comb begin
    nh     = {hist_q[PAT_LEN-2:0], w};
    nf     = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    // match is gated by the fill level so an all-zero pattern cannot fire on reset history
    match  = en && !clr && (nf == FULL) && (nh == PATTERN);
    flush  = clr || (match && !overlap);
    hist_d = flush ? '0 : en ? nh : hist_q;
    fill_d = flush ? '0 : en ? nf : fill_q;
    cnt_d  = clr ? '0 : (match && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    z_d    = match;
  end
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end
  assign Z   = z_q;
  assign cnt = cnt_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: three parameterisations driven in parallel, scoreboarded
// against a bit-stream reference model.
module tb_seq_detector_param;
  logic clock = 1'b0, rst = 1'b0, en = 1'b0, clr = 1'b0, overlap = 1'b0, w = 1'b0;
  logic za, zb, zc;
  logic [7:0] ca, cb;
  logic [1:0] cc;
  always #5 clock = ~clock;

  seq_detector_param u_a (.clock(clock), .rst(rst), .en(en), .clr(clr), .overlap(overlap), .w(w), .Z(za), .cnt(ca));
  seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b10110), .CNT_W(8)) u_b (
    .clock(clock), .rst(rst), .en(en), .clr(clr), .overlap(overlap), .w(w), .Z(zb), .cnt(cb));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(2)) u_c (
    .clock(clock), .rst(rst), .en(en), .clr(clr), .overlap(overlap), .w(w), .Z(zc), .cnt(cc));

  typedef struct packed {
    logic [2:0]      z;
    logic [2:0][7:0] c;
  } exp_t;

  exp_t q[$];
  int plen[3] = '{4, 5, 4};
  int pval[3] = '{15, 22, 15};
  int cmax[3] = '{255, 255, 3};
  int nbits[3], recent[3], mcnt[3];
  int checks = 0, fails = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  // A match needs L valid bits since the last flush and the newest L of them equal to the pattern.
  task automatic step(input logic e, input logic wv);
    exp_t x;
    int nr;
    bit m;
    en = e;
    w  = wv;
    @(posedge clock);
    x = '0;
    for (int i = 0; i < 3; i++) begin
      if (!rst || clr) begin
        nbits[i] = 0;
        recent[i] = 0;
        if (!rst || clr) mcnt[i] = 0;
      end else if (en) begin
        nr = ((recent[i] * 2) + int'(w)) % (1 << plen[i]);
        m  = (nbits[i] + 1 >= plen[i]) && (nr == pval[i]);
        x.z[i] = m;
        if (m && mcnt[i] < cmax[i]) mcnt[i]++;
        if (m && !overlap) begin
          nbits[i] = 0;
          recent[i] = 0;
        end else begin
          nbits[i]++;
          recent[i] = nr;
        end
      end
      x.c[i] = 8'(mcnt[i]);
    end
    q.push_back(x);
    #1;
  endtask

  task automatic ones(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b1);
  endtask

  task automatic bits(input logic [15:0] v, input int k);
    for (int i = k - 1; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task automatic areset();
    q.delete();
    rst = 1'b0;
    #1;
    check("async_Z_a", 8'(za), 8'd0);
    check("async_Z_b", 8'(zb), 8'd0);
    check("async_Z_c", 8'(zc), 8'd0);
    check("async_cnt_a", ca, 8'd0);
    check("async_cnt_b", cb, 8'd0);
    check("async_cnt_c", 8'(cc), 8'd0);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check("Z_a", 8'(za), 8'(x.z[0]));
      check("Z_b", 8'(zb), 8'(x.z[1]));
      check("Z_c", 8'(zc), 8'(x.z[2]));
      check("cnt_a", ca, x.c[0]);
      check("cnt_b", cb, x.c[1]);
      check("cnt_c", 8'(cc), x.c[2]);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      nbits[i] = 0;
      recent[i] = 0;
      mcnt[i] = 0;
    end
    ones(6);
    rst = 1'b1;
    ones(4);
    step(1'b1, 1'b0);
    overlap = 1'b1;
    ones(7);
    step(1'b1, 1'b0);
    overlap = 1'b0;
    ones(8);
    step(1'b1, 1'b0);
    ones(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    ones(2);
    step(1'b1, 1'b0);
    bits(16'b11101111, 8);
    step(1'b1, 1'b0);
    overlap = 1'b1;
    bits(16'b10110110, 8);
    ones(10);
    clr = 1'b1;
    step(1'b1, 1'b1);
    clr = 1'b0;
    ones(4);
    step(1'b1, 1'b0);
    ones(3);
    #2;
    areset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b1;
    ones(4);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 2) begin
        areset();
        step(1'b1, 1'(($urandom_range(1))));
        rst = 1'b1;
      end
      clr = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 10) overlap = 1'($urandom_range(1));
      step(($urandom_range(99) < 80), ($urandom_range(99) < 65));
    end
    clr = 1'b0;
    step(1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
